beep_pattern_driver: RTL and testbench

- Downstream consumer of the beep timer's `fullflag` output.
- Each trigger rising edge produces a burst of `beepCount` tones on a buzzer pin: square wave, programmable pitch, tone length and inter-tone gap.
- Its output drives the passive buzzer pad directly.

---
 rtl/beep_pkg.sv | 15 +
 rtl/beep_square_gen.sv | 34 +++
 rtl/beep_pattern_driver.sv | 149 ++++++++++++++
 tb/tb_beep_pattern_driver.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/beep_pkg.sv
// Shared constants and state encoding for the beep timer and beep pattern driver.
package beep_pkg;

   localparam int CNT_W = 32;
   localparam int HP_W  = 16;
   localparam int NUM_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TONE = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/beep_square_gen.sv
// Square-wave generator: starts high whenever run rises and toggles every
// max(halfPeriod,1) cycles; output is held low while run is low.
module beep_square_gen #(
   parameter int HP_W = beep_pkg::HP_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
   input  logic [HP_W-1:0] halfPeriod,
   output logic            sq
);

   logic [HP_W-1:0] hp_cnt_q;
   logic [HP_W-1:0] hp_last;
   logic            phase_q;

   // A zero half-period behaves like one, so the last count index is 0 either way.
   assign hp_last = (halfPeriod == '0) ? '0 : halfPeriod - HP_W'(1);

   always_ff @(posedge clk) begin
      if (rst || !run) begin
         hp_cnt_q <= '0;
         phase_q  <= 1'b1;
      end else if (hp_cnt_q >= hp_last) begin
         hp_cnt_q <= '0;
         phase_q  <= ~phase_q;
      end else begin
         hp_cnt_q <= hp_cnt_q + HP_W'(1);
      end
   end

   assign sq = run & phase_q;

endmodule

// File: rtl/beep_pattern_driver.sv
// Burst sequencer: each accepted trig rising edge plays beepCount tones with
// programmable pitch, tone length and gap, driving the buzzer pad directly.
module beep_pattern_driver #(
   parameter int CNT_W = beep_pkg::CNT_W,
   parameter int HP_W  = beep_pkg::HP_W,
   parameter int NUM_W = beep_pkg::NUM_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             trig,
   input  logic [HP_W-1:0]  halfPeriod,
   input  logic [CNT_W-1:0] toneLen,
   input  logic [CNT_W-1:0] gapLen,
   input  logic [NUM_W-1:0] beepCount,
   input  logic             clrOverrun,
   output logic             buzzer,
   output logic             busy,
   output logic             done,
   output logic [NUM_W-1:0] beepIdx,
   output logic             overrun
);

   import beep_pkg::*;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [NUM_W-1:0] idx_q, idx_d;
   logic             trig_q;
   logic             trig_rise;
   logic             accept;
   logic             overrun_q;
   logic             overrun_set;

   logic [HP_W-1:0]  hp_q;
   logic [CNT_W-1:0] tone_q;
   logic [CNT_W-1:0] gap_q;
   logic [NUM_W-1:0] count_q;

   logic [CNT_W-1:0] tone_last;
   logic [CNT_W-1:0] gap_last;
   logic [NUM_W:0]   idx_inc;
   logic             more_tones;

   assign trig_rise   = trig & ~trig_q;
   assign overrun_set = trig_rise & enable & (state_q != IDLE);

   assign tone_last  = (tone_q == '0) ? '0 : tone_q - CNT_W'(1);
   assign gap_last   = (gap_q  == '0) ? '0 : gap_q  - CNT_W'(1);
   assign idx_inc    = {1'b0, idx_q} + (NUM_W + 1)'(1);
   assign more_tones = idx_inc < {1'b0, count_q};

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      accept  = 1'b0;
      if (!enable) begin
         state_d = IDLE;
         cnt_d   = '0;
         idx_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (trig_rise) begin
                  accept  = 1'b1;
                  cnt_d   = '0;
                  idx_d   = '0;
                  state_d = (beepCount == '0) ? DONE : TONE;
               end
            end
            TONE: begin
               if (cnt_q == tone_last) begin
                  cnt_d = '0;
                  if (more_tones) begin
                     idx_d   = idx_inc[NUM_W-1:0];
                     state_d = (gap_q == '0) ? TONE : GAP;
                  end else begin
                     state_d = DONE;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            GAP: begin
               if (cnt_q == gap_last) begin
                  cnt_d   = '0;
                  state_d = TONE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            DONE: begin
               state_d = IDLE;
               idx_d   = '0;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so all of them sample pre-edge values.
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         trig_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         trig_q  <= trig;
         if (overrun_set) begin
            overrun_q <= 1'b1;
         end else if (clrOverrun) begin
            overrun_q <= 1'b0;
         end
      end
   end

   // NOTE: operand registers are only read after an accept loads them, so they carry no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         hp_q    <= halfPeriod;
         tone_q  <= toneLen;
         gap_q   <= gapLen;
         count_q <= beepCount;
      end
   end

   beep_square_gen #(
      .HP_W (HP_W)
   ) u_square_gen (
      .clk        (clk),
      .rst        (rst),
      .run        (state_q == TONE),
      .halfPeriod (hp_q),
      .sq         (buzzer)
   );

   assign busy    = (state_q == TONE) || (state_q == GAP);
   assign done    = (state_q == DONE);
   assign beepIdx = idx_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_beep_pattern_driver.sv
// Directed bench for beep_pattern_driver; expected waveforms come from a
// burst timeline model driven by the operands the bench applies.
module tb_beep_pattern_driver;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        trig;
   logic [15:0] halfPeriod;
   logic [31:0] toneLen;
   logic [31:0] gapLen;
   logic [3:0]  beepCount;
   logic        clrOverrun;
   logic        buzzer;
   logic        busy;
   logic        done;
   logic [3:0]  beepIdx;
   logic        overrun;

   int errors = 0;
   int checks = 0;

   int m_hp, m_tone, m_gap, m_cnt;

   typedef struct packed {
      logic       busy;
      logic       buzz;
      logic       done;
      logic [3:0] idx;
   } exp_t;

   beep_pattern_driver dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .trig       (trig),
      .halfPeriod (halfPeriod),
      .toneLen    (toneLen),
      .gapLen     (gapLen),
      .beepCount  (beepCount),
      .clrOverrun (clrOverrun),
      .buzzer     (buzzer),
      .busy       (busy),
      .done       (done),
      .beepIdx    (beepIdx),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // k = 0 is the first cycle after the accepting clock edge.
   function automatic exp_t model(input int k);
      exp_t e;
      int per, total, j, t;
      e = '0;
      if (m_cnt == 0) begin
         e.done = (k == 0);
         return e;
      end
      per   = m_tone + m_gap;
      total = m_cnt * m_tone + (m_cnt - 1) * m_gap;
      if (k < total) begin
         j = k / per;
         t = k % per;
         e.busy = 1'b1;
         if (t < m_tone) begin
            e.idx  = 4'(j);
            e.buzz = ((t / m_hp) % 2) == 0;
         end else begin
            e.idx = 4'(j + 1);
         end
      end else if (k == total) begin
         e.done = 1'b1;
         e.idx  = 4'(m_cnt - 1);
      end
      return e;
   endfunction

   task automatic check_span(input string tag, input int k0, input int k1);
      exp_t e;
      for (int k = k0; k < k1; k++) begin
         e = model(k);
         check($sformatf("%s busy k=%0d", tag, k), 32'(busy), 32'(e.busy));
         check($sformatf("%s buzzer k=%0d", tag, k), 32'(buzzer), 32'(e.buzz));
         check($sformatf("%s done k=%0d", tag, k), 32'(done), 32'(e.done));
         check($sformatf("%s idx k=%0d", tag, k), 32'(beepIdx), 32'(e.idx));
         tick();
      end
   endtask

   task automatic set_ops(input int hp, input int tone, input int gap, input int cnt);
      halfPeriod = 16'(hp);
      toneLen    = 32'(tone);
      gapLen     = 32'(gap);
      beepCount  = 4'(cnt);
      m_hp   = (hp == 0) ? 1 : hp;
      m_tone = (tone == 0) ? 1 : tone;
      m_gap  = gap;
      m_cnt  = cnt;
   endtask

   task automatic start_burst(input int hp, input int tone, input int gap, input int cnt);
      set_ops(hp, tone, gap, cnt);
      trig = 1'b1;
      tick();
      trig = 1'b0;
   endtask

   initial begin
      rst = 1'b1; enable = 1'b1; trig = 1'b0; clrOverrun = 1'b0;
      halfPeriod = '0; toneLen = '0; gapLen = '0; beepCount = '0;
      tick();
      tick();
      check("reset buzzer", 32'(buzzer), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset idx", 32'(beepIdx), 32'd0);
      check("reset overrun", 32'(overrun), 32'd0);
      rst = 1'b0;
      tick();

      // Single burst: 40-cycle tone, half-period 5, done at k=40.
      start_burst(5, 40, 0, 1);
      check_span("single", 0, 43);

      // Multi-beep; operand changes mid-burst must be ignored.
      start_burst(2, 20, 10, 3);
      halfPeriod = 16'd7; toneLen = 32'd3; gapLen = 32'd1; beepCount = 4'd9;
      check_span("multi", 0, 83);

      // beepCount = 0 is a bare done pulse; zero pitch/length act as one.
      start_burst(4, 10, 0, 0);
      check_span("zero_count", 0, 3);
      start_burst(0, 0, 0, 1);
      check_span("zero_len", 0, 3);

      // Overrun: second edge mid-tone leaves the burst length unchanged.
      start_burst(3, 30, 0, 1);
      check_span("ovr_a", 0, 5);
      trig = 1'b1;
      check_span("ovr_a", 5, 6);
      trig = 1'b0;
      check_span("ovr_a", 6, 33);
      check("overrun sticky", 32'(overrun), 32'd1);
      clrOverrun = 1'b1;
      tick();
      clrOverrun = 1'b0;
      check("overrun cleared", 32'(overrun), 32'd0);
      start_burst(3, 30, 0, 1);
      check_span("ovr_b", 0, 4);
      trig = 1'b1; clrOverrun = 1'b1;
      check_span("ovr_b", 4, 5);
      trig = 1'b0; clrOverrun = 1'b0;
      check("overrun set wins", 32'(overrun), 32'd1);
      check_span("ovr_b", 5, 33);

      // Abort in the gap following beep index 1.
      start_burst(2, 8, 6, 3);
      check_span("abort", 0, 25);
      enable = 1'b0;
      tick();
      check("abort busy", 32'(busy), 32'd0);
      check("abort buzzer", 32'(buzzer), 32'd0);
      check("abort idx", 32'(beepIdx), 32'd0);
      check("abort overrun kept", 32'(overrun), 32'd1);
      for (int i = 0; i < 12; i++) begin
         check($sformatf("abort no done %0d", i), 32'(done), 32'd0);
         tick();
      end
      enable = 1'b1;
      tick();

      // Synchronous reset mid-tone also clears overrun.
      start_burst(2, 20, 0, 1);
      check_span("rst", 0, 4);
      rst = 1'b1;
      tick();
      check("rst busy", 32'(busy), 32'd0);
      check("rst buzzer", 32'(buzzer), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst idx", 32'(beepIdx), 32'd0);
      check("rst overrun", 32'(overrun), 32'd0);
      rst = 1'b0;
      tick();

      // Level trig held for 100 cycles: one burst, no overrun.
      set_ops(1, 10, 5, 2);
      trig = 1'b1;
      tick();
      check_span("level", 0, 27);
      for (int i = 0; i < 72; i++) begin
         check($sformatf("level idle busy %0d", i), 32'(busy), 32'd0);
         check($sformatf("level idle done %0d", i), 32'(done), 32'd0);
         tick();
      end
      trig = 1'b0;
      tick();
      check("level overrun", 32'(overrun), 32'd0);
      check("level busy", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
